pingpong_buf_4bits: RTL
=======================

// Module: pingpong_buf_4bits
// PURPOSE
//  Two-entry 4-bit ping-pong buffer that sits directly upstream of the 4-bit 2:1 mux stage.
//  Incoming words alternate between storage registers reg0/reg1, which drive mux inputs d0/d1.
//  The read pointer drives mux select s, so the mux output is the oldest stored word.
//  Decouples a 4-bit producer from a consumer with valid/ready handshakes on both sides.
// PARAMETERS
//  RESET_DATA  4'b0000  value loaded into reg0/reg1 on reset
// PORTS
//  clk        in   1  clock; all state updates on rising edge
//  reset_n    in   1  reset, asynchronous assert, active-low
//  in_valid   in   1  producer presents in_data this cycle
//  in_data    in   4  write data
//  in_ready   out  1  buffer accepts a word this cycle
//  out_valid  out  1  out_data holds a stored word
//  out_data   out  4  oldest stored word (2:1 mux output)
//  out_ready  in   1  consumer takes out_data this cycle
//  ovf        out  1  sticky overflow flag (only with PINGPONG_OVF_EN)
// BEHAVIOUR
//  - State: wr_ptr (1b), rd_ptr (1b), count (2b, values 0..2), reg0/reg1 (4b each).
//  - Reset (reset_n=0, async): wr_ptr=0, rd_ptr=0, count=0, reg0=reg1=RESET_DATA, ovf=0.
//    Resulting outputs: in_ready=1, out_valid=0, out_data=RESET_DATA.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != 2); out_valid = (count != 0). Both combinational from state only.
//    Neither depends on the same-cycle in_valid or out_ready.
//  - Push: reg[wr_ptr] <= in_data; wr_ptr toggles (wraps 1->0).
//  - Pop: rd_ptr toggles (wraps 1->0). The register is not cleared; its stale data stays.
//  - count next value: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - out_data = rd_ptr ? reg1 : reg0, through the 4-bit 2:1 mux (d0=reg0, d1=reg1, s=rd_ptr).
//  - Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N.
//    No same-cycle bypass: when count=0, out_valid stays 0 in the push cycle.
//  - Occupancy states by count:
//    EMPTY(0) -push-> HALF(1);
//    HALF -push only-> FULL(2); HALF -pop only-> EMPTY; HALF -push & pop-> HALF;
//    FULL -pop-> HALF.
//  - FULL: in_ready=0, so a push is impossible even if a pop occurs the same cycle.
//    The slot reopens the next cycle.
//  - EMPTY: out_ready is ignored; rd_ptr and count do not change.
//  - Ordering: strict FIFO; words leave in arrival order across pointer wrap.
//  - reset_n deasserted mid-stream: all stored words are discarded; the buffer returns to EMPTY.
// CONFIGURATION
//  - Macro PINGPONG_OVF_EN.
//  - Defined: port ovf exists. ovf <= 1 on any edge where in_valid=1 and in_ready=0.
//    ovf stays 1 until reset. The rejected word is not stored.
//  - Undefined: port ovf and its logic are absent. A rejected in_valid is silently held off.
// TESTING
//  1. Reset: reset_n=0 with data toggling -> in_ready=1, out_valid=0, out_data=4'h0.
//  2. Push 4'hA then 4'h5 with out_ready=0 -> count=2, in_ready=0.
//     Then out_ready=1 -> out_data A, then 5; then out_valid=0.
//  3. Steady stream: in_valid=out_ready=1 for 8 cycles with data 1..8 -> out_data=1..8 in order.
//     Checks wrap of both pointers; count toggles between 1 and 1 with no drift.
//  4. FULL with pop and in_valid the same cycle (data 4'hC) -> pop taken, 4'hC not stored.
//     count=1; 4'hC accepted the next cycle.
//  5. Async reset mid-stream (count=2, pulse asserted between edges) -> outputs reset immediately.
//     Next out_valid only after a new push.
//  6. PINGPONG_OVF_EN defined: push 3 words with out_ready=0 -> ovf=1 after the 3rd edge.
//     ovf stays 1 after draining; cleared only by reset_n=0.

Source files
------------

// File: rtl/pingpong_buf_4bits.sv
// Two-entry 4-bit ping-pong buffer feeding a 2:1 mux, with valid/ready on both sides.
// Optional sticky overflow flag enabled by defining PINGPONG_OVF_EN.
module pingpong_buf_4bits #(
  parameter logic [3:0] RESET_DATA = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready
`ifdef PINGPONG_OVF_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t       state, state_next;
  logic       wr_ptr, rd_ptr;
  logic [3:0] reg0, reg1;
  logic       push, pop;

  // Handshake readiness depends on occupancy only, never on same-cycle inputs
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Read pointer is the 2:1 mux select, so the oldest word is always presented
  assign out_data  = rd_ptr ? reg1 : reg0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (push) state_next = HALF;
      HALF: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = HALF;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      reg0   <= RESET_DATA;
      reg1   <= RESET_DATA;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
        if (wr_ptr) reg1 <= in_data;
        else        reg0 <= in_data;
      end
      // Popped slots keep their stale contents; only the pointer moves
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

`ifdef PINGPONG_OVF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule
